// File: rtl/seg7_pkg.sv
// Shared definitions for the multiplexed 7-segment scan driver:
// segment bit positions, the hex glyph table and the scan state encoding.
package seg7_pkg;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  localparam logic [6:0] M_A = 7'(1 << SEG_A);
  localparam logic [6:0] M_B = 7'(1 << SEG_B);
  localparam logic [6:0] M_C = 7'(1 << SEG_C);
  localparam logic [6:0] M_D = 7'(1 << SEG_D);
  localparam logic [6:0] M_E = 7'(1 << SEG_E);
  localparam logic [6:0] M_F = 7'(1 << SEG_F);
  localparam logic [6:0] M_G = 7'(1 << SEG_G);

  // Active-high glyphs; entry 0 is the rightmost element of the concatenation.
  localparam logic [15:0][6:0] HEX_TABLE = {
    M_A | M_E | M_F | M_G,                     // F
    M_A | M_D | M_E | M_F | M_G,               // E
    M_B | M_C | M_D | M_E | M_G,               // d
    M_A | M_D | M_E | M_F,                     // C
    M_C | M_D | M_E | M_F | M_G,               // b
    M_A | M_B | M_C | M_E | M_F | M_G,         // A
    M_A | M_B | M_C | M_D | M_F | M_G,         // 9
    M_A | M_B | M_C | M_D | M_E | M_F | M_G,   // 8
    M_A | M_B | M_C,                           // 7
    M_A | M_C | M_D | M_E | M_F | M_G,         // 6
    M_A | M_C | M_D | M_F | M_G,               // 5
    M_B | M_C | M_F | M_G,                     // 4
    M_A | M_B | M_C | M_D | M_G,               // 3
    M_A | M_B | M_D | M_E | M_G,               // 2
    M_B | M_C,                                 // 1
    M_A | M_B | M_C | M_D | M_E | M_F          // 0
  };

  typedef enum logic [1:0] {
    ST_OFF,
    ST_GAP,
    ST_SHOW
  } scan_state_e;

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble-to-glyph lookup; output is active-high, polarity is
// applied by the caller.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] segments
);

  assign segments = HEX_TABLE[nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit hex display driver with a blanking gap per slot,
// leading-zero suppression and a frame-aligned double-buffered value.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int N_DIGITS       = 4,
  parameter int REFRESH_DIV    = 50000,
  parameter int BLANK_CYCLES   = 500,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int COM_ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*N_DIGITS-1:0]   value,
  input  logic [N_DIGITS-1:0]     dp_in,
  input  logic                    lz_en,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [N_DIGITS-1:0]     com,
  output logic                    frame_tick
);

  localparam int DIG_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int PS_W  = $clog2(REFRESH_DIV);

  localparam logic [PS_W-1:0]     PS_LAST  = PS_W'(REFRESH_DIV - 1);
  localparam logic [PS_W-1:0]     PS_BLANK = PS_W'(BLANK_CYCLES);
  localparam logic [DIG_W-1:0]    DIG_LAST = DIG_W'(N_DIGITS - 1);
  localparam logic                SEG_POL  = (SEG_ACTIVE_LOW != 0);
  localparam logic                COM_POL  = (COM_ACTIVE_LOW != 0);
  localparam logic [6:0]          SEG_INV  = {7{SEG_POL}};
  localparam logic [N_DIGITS-1:0] COM_INV  = {N_DIGITS{COM_POL}};

  scan_state_e                state_q, state_d;
  logic [PS_W-1:0]            prescaler_q, prescaler_d;
  logic [DIG_W-1:0]           digit_q, digit_d;
  logic [4*N_DIGITS-1:0]      active_value_q, active_value_d;
  logic [N_DIGITS-1:0]        active_dp_q, active_dp_d;
  logic [4*N_DIGITS-1:0]      pending_value_q, pending_value_d;
  logic [N_DIGITS-1:0]        pending_dp_q, pending_dp_d;
  logic                       pending_valid_q, pending_valid_d;
  logic [6:0]                 seg_q, seg_d;
  logic                       dp_q, dp_d;
  logic [N_DIGITS-1:0]        com_q, com_d;

  logic [3:0]                 nibbles [N_DIGITS];
  logic [N_DIGITS-1:0]        nib_zero;
  logic [N_DIGITS-1:0]        digit_onehot;
  logic [6:0]                 cur_segments;
  logic                       blank_digit;

  for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_digit
    assign nibbles[gi]      = active_value_q[4*gi +: 4];
    assign nib_zero[gi]     = (active_value_q[4*gi +: 4] == 4'h0);
    assign digit_onehot[gi] = (digit_q == DIG_W'(gi));
  end

  seg7_hex_decode u_hex_decode (
    .nibble   (nibbles[digit_q]),
    .segments (cur_segments)
  );

  assign frame_tick = (state_q != ST_OFF) && (digit_q == DIG_LAST) && (prescaler_q == PS_LAST);

  // A digit is suppressed when it and every more-significant nibble are zero.
  always_comb begin
    logic zero_run;
    zero_run    = 1'b1;
    blank_digit = 1'b0;
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      zero_run = zero_run & nib_zero[k];
      if (digit_q == DIG_W'(k)) begin
        blank_digit = lz_en && zero_run && (k != 0);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    prescaler_d = prescaler_q;
    digit_d     = digit_q;
    if (!enable) begin
      state_d     = ST_OFF;
      prescaler_d = '0;
      digit_d     = '0;
    end else if (state_q == ST_OFF) begin
      state_d     = ST_GAP;
      prescaler_d = '0;
      digit_d     = '0;
    end else begin
      if (prescaler_q == PS_LAST) begin
        prescaler_d = '0;
        digit_d     = (digit_q == DIG_LAST) ? '0 : digit_q + 1'b1;
      end else begin
        prescaler_d = prescaler_q + 1'b1;
      end
      state_d = (prescaler_d < PS_BLANK) ? ST_GAP : ST_SHOW;
    end
  end

  // Swapping only on the frame boundary keeps a frame from mixing two values.
  always_comb begin
    active_value_d  = active_value_q;
    active_dp_d     = active_dp_q;
    pending_value_d = pending_value_q;
    pending_dp_d    = pending_dp_q;
    pending_valid_d = pending_valid_q;
    if (frame_tick && load) begin
      active_value_d  = value;
      active_dp_d     = dp_in;
      pending_valid_d = 1'b0;
    end else if (frame_tick && pending_valid_q) begin
      active_value_d  = pending_value_q;
      active_dp_d     = pending_dp_q;
      pending_valid_d = 1'b0;
    end else if (load) begin
      pending_value_d = value;
      pending_dp_d    = dp_in;
      pending_valid_d = 1'b1;
    end
  end

  always_comb begin
    seg_d = SEG_INV;
    dp_d  = SEG_POL;
    com_d = COM_INV;
    if (enable && (state_q == ST_SHOW) && !blank_digit) begin
      seg_d = cur_segments ^ SEG_INV;
      dp_d  = active_dp_q[digit_q] ^ SEG_POL;
      com_d = digit_onehot ^ COM_INV;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_GAP;
      prescaler_q     <= '0;
      digit_q         <= '0;
      active_value_q  <= '0;
      active_dp_q     <= '0;
      pending_value_q <= '0;
      pending_dp_q    <= '0;
      pending_valid_q <= 1'b0;
      seg_q           <= SEG_INV;
      dp_q            <= SEG_POL;
      com_q           <= COM_INV;
    end else begin
      state_q         <= state_d;
      prescaler_q     <= prescaler_d;
      digit_q         <= digit_d;
      active_value_q  <= active_value_d;
      active_dp_q     <= active_dp_d;
      pending_value_q <= pending_value_d;
      pending_dp_q    <= pending_dp_d;
      pending_valid_q <= pending_valid_d;
      seg_q           <= seg_d;
      dp_q            <= dp_d;
      com_q           <= com_d;
    end
  end

  assign seg = seg_q;
  assign dp  = dp_q;
  assign com = com_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver (4 digits, 8-cycle slots, 2-cycle gap,
// active-low segments and commons): per-cycle scoreboard plus per-frame digit checks.
module tb_seg7_scan_driver;

  localparam int RD    = 8;
  localparam int BL    = 2;
  localparam int FRAME = 4 * RD;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b1;
  logic        load = 1'b0;
  logic        lz_en = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  com;
  logic        frame_tick;

  seg7_scan_driver #(
    .N_DIGITS       (4),
    .REFRESH_DIV    (RD),
    .BLANK_CYCLES   (BL),
    .SEG_ACTIVE_LOW (1),
    .COM_ACTIVE_LOW (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .load       (load),
    .value      (value),
    .dp_in      (dp_in),
    .lz_en      (lz_en),
    .seg        (seg),
    .dp         (dp),
    .com        (com),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] com;
    logic [6:0] seg;
    logic       dp;
    logic       tick;
  } obs_t;

  obs_t sb_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Reference state: frame position 0..31 rather than slot/prescaler pairs.
  bit          m_off = 1'b0;
  int          m_t = 0;
  logic [15:0] m_act = '0;
  logic [15:0] m_pend = '0;
  logic [3:0]  m_act_dp = '0;
  logic [3:0]  m_pend_dp = '0;
  bit          m_pv = 1'b0;

  bit          dir_on = 1'b0;
  logic [6:0]  dir_seg [4];
  logic [3:0]  dir_com [4];
  logic        dir_dp [4];
  int          k_after_tick = 1000;
  bit          last_tick = 1'b0;

  function automatic logic [6:0] seg_low(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic obs_t model_out();
    obs_t        o;
    int          d;
    logic [15:0] upper;
    o = '{com: 4'hF, seg: 7'h7F, dp: 1'b1, tick: 1'b0};
    if (!rst && enable && !m_off && (m_t % RD) >= BL) begin
      d     = m_t / RD;
      upper = m_act >> (4 * d);
      if (!(lz_en && d != 0 && upper == 16'h0)) begin
        o.com = ~(4'b0001 << d);
        o.seg = seg_low(m_act[4*d +: 4]);
        o.dp  = ~m_act_dp[d];
      end
    end
    return o;
  endfunction

  task automatic step();
    obs_t e;
    bit   tick_now;
    int   d;
    e = model_out();
    if (rst) begin
      m_off = 1'b0; m_t = 0; m_act = '0; m_act_dp = '0;
      m_pend = '0; m_pend_dp = '0; m_pv = 1'b0;
    end else begin
      tick_now = !m_off && (m_t == FRAME - 1);
      if (tick_now && load) begin
        m_act = value; m_act_dp = dp_in; m_pv = 1'b0;
      end else if (tick_now && m_pv) begin
        m_act = m_pend; m_act_dp = m_pend_dp; m_pv = 1'b0;
      end else if (load) begin
        m_pend = value; m_pend_dp = dp_in; m_pv = 1'b1;
      end
      if (!enable) begin
        m_off = 1'b1; m_t = 0;
      end else if (m_off) begin
        m_off = 1'b0; m_t = 0;
      end else begin
        m_t = (m_t + 1) % FRAME;
      end
    end
    e.tick = !m_off && (m_t == FRAME - 1);
    sb_q.push_back(e);

    @(posedge clk);
    @(negedge clk);
    e = sb_q.pop_front();
    chk("com", 32'(com), 32'(e.com));
    chk("seg", 32'(seg), 32'(e.seg));
    chk("dp", 32'(dp), 32'(e.dp));
    chk("frame_tick", 32'(frame_tick), 32'(e.tick));

    k_after_tick++;
    if (dir_on && k_after_tick < FRAME) begin
      d = k_after_tick / RD;
      if (k_after_tick % RD == 1) chk("gap_com", 32'(com), 32'h0000000F);
      if (k_after_tick % RD == 5) begin
        chk("digit_com", 32'(com), 32'(dir_com[d]));
        chk("digit_seg", 32'(seg), 32'(dir_seg[d]));
        chk("digit_dp", 32'(dp), 32'(dir_dp[d]));
      end
    end
    last_tick = (frame_tick === 1'b1);
    if (last_tick) k_after_tick = -1;
  endtask

  task automatic set_dir(input logic [27:0] segs, input logic [15:0] coms, input logic [3:0] dps);
    for (int i = 0; i < 4; i++) begin
      dir_seg[i] = segs[7*i +: 7];
      dir_com[i] = coms[4*i +: 4];
      dir_dp[i]  = dps[i];
    end
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    value = v; dp_in = d; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic run_to_tick();
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!last_tick && n < 200);
    if (!last_tick) chk("tick_timeout", 32'(frame_tick), 32'd1);
  endtask

  // Call only right after a frame_tick cycle; checks one full frame.
  task automatic frame();
    dir_on = 1'b1;
    repeat (FRAME) step();
    dir_on = 1'b0;
  endtask

  task automatic count_to_tick(input string tag);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!last_tick && n < 200);
    chk(tag, 32'(n), 32'(FRAME));
  endtask

  localparam logic [15:0] COMS_ALL = 16'h7BDE;
  localparam logic [27:0] SEGS_0000 = {7'h40, 7'h40, 7'h40, 7'h40};

  initial begin
    repeat (3) step();
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_com", 32'(com), 32'hF);
    chk("rst_dp", 32'(dp), 32'h1);
    chk("rst_tick", 32'(frame_tick), 32'h0);
    rst = 1'b0;
    run_to_tick();
    set_dir(SEGS_0000, COMS_ALL, 4'hF);
    frame();

    // Basic decode with a decimal point on digit 2.
    repeat (3) step();
    do_load(16'h12AF, 4'b0100);
    run_to_tick();
    set_dir({7'h79, 7'h24, 7'h08, 7'h0E}, COMS_ALL, 4'b1011);
    frame();

    // Leading-zero suppression.
    lz_en = 1'b1;
    repeat (5) step();
    do_load(16'h0050, 4'b0000);
    run_to_tick();
    set_dir({7'h7F, 7'h7F, 7'h12, 7'h40}, 16'hFFDE, 4'hF);
    frame();
    set_dir({7'h7F, 7'h7F, 7'h7F, 7'h40}, 16'hFFFE, 4'hF);
    dir_on = 1'b1;
    do_load(16'h0000, 4'b0000);
    repeat (FRAME - 1) step();
    dir_on = 1'b0;
    lz_en = 1'b0;

    // Mid-frame load leaves the current frame alone.
    set_dir(SEGS_0000, COMS_ALL, 4'hF);
    dir_on = 1'b1;
    repeat (10) step();
    do_load(16'h3333, 4'b0000);
    repeat (21) step();
    dir_on = 1'b0;
    set_dir({7'h30, 7'h30, 7'h30, 7'h30}, COMS_ALL, 4'hF);
    frame();

    // Two loads in one frame: the last wins.
    dir_on = 1'b1;
    repeat (5) step();
    do_load(16'h1111, 4'b0000);
    repeat (5) step();
    do_load(16'h4567, 4'b0000);
    repeat (20) step();
    dir_on = 1'b0;
    set_dir({7'h19, 7'h12, 7'h02, 7'h78}, COMS_ALL, 4'hF);
    frame();

    // Load coinciding with frame_tick lands in the very next frame.
    set_dir({7'h00, 7'h10, 7'h08, 7'h03}, COMS_ALL, 4'hF);
    dir_on = 1'b1;
    do_load(16'h89AB, 4'b0000);
    repeat (FRAME - 1) step();
    dir_on = 1'b0;

    // Enable dropped during digit 2 SHOW, then restored.
    repeat (20) step();
    enable = 1'b0;
    step();
    chk("off_com", 32'(com), 32'hF);
    chk("off_seg", 32'(seg), 32'h7F);
    repeat (4) step();
    enable = 1'b1;
    count_to_tick("reenable_tick");
    count_to_tick("tick_period");

    // Reset mid-SHOW with a pending value discards it.
    repeat (4) step();
    do_load(16'h5A5A, 4'b0000);
    repeat (4) step();
    rst = 1'b1;
    step();
    chk("midrst_com", 32'(com), 32'hF);
    chk("midrst_seg", 32'(seg), 32'h7F);
    rst = 1'b0;
    run_to_tick();
    set_dir(SEGS_0000, COMS_ALL, 4'hF);
    frame();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
Multiplexed N-digit hexadecimal 7-segment display driver. It is the parametrised successor of the single-digit combinational hex decoder. It time-scans N_DIGITS common-electrode digits, with per-digit decimal points, leading-zero suppression and an anti-ghosting blank gap between digits. The displayed value is double-buffered, so host updates never tear mid-frame. It sits between the board's value/status logic and the display pins.

Parameters:
N_DIGITS, 4, number of digits scanned (1..8)
REFRESH_DIV, 50000, clock cycles per digit slot (>= BLANK_CYCLES+2)
BLANK_CYCLES, 500, cycles at start of each slot with all com inactive (>= 1)
SEG_ACTIVE_LOW, 1, 1 = segment/dp outputs active-low
COM_ACTIVE_LOW, 1, 1 = digit commons active-low

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
enable  in  1  1 = scanning; 0 = display dark
load  in  1  one-cycle strobe capturing value/dp_in
value  in  4*N_DIGITS  hex nibbles; nibble k drives digit k (k=0 rightmost)
dp_in  in  N_DIGITS  decimal point per digit
lz_en  in  1  leading-zero suppression enable
seg  out  7  {g,f,e,d,c,b,a}
dp  out  1  decimal point of current digit
com  out  N_DIGITS  digit commons, one-hot active
frame_tick  out  1  one-cycle pulse at end of each frame

Behaviour:
- The clock is clk. The reset is rst, synchronous and active-high. Everything is in the single clk domain.
- Reset:
  - seg, dp and com are all inactive (polarity per parameters), and frame_tick is 0.
  - The active and pending registers are cleared to 0, and pending_valid is 0.
  - digit_idx is 0, the prescaler is 0, and the state is GAP.
  - Reset asserted mid-frame takes effect at the next edge.
- States:
  - OFF: entered when enable=0. Outputs inactive, counters held at 0.
  - GAP: prescaler < BLANK_CYCLES. com all inactive.
  - SHOW: prescaler >= BLANK_CYCLES. com[digit_idx] active and seg/dp show digit digit_idx.
- Transitions:
  - OFF to GAP (digit 0, prescaler 0) when enable=1.
  - Any state to OFF when enable=0.
- Prescaler:
  - Counts 0..REFRESH_DIV-1, then wraps.
  - On wrap, digit_idx increments modulo N_DIGITS.
  - Frame length is N_DIGITS*REFRESH_DIV cycles.
- frame_tick is high for exactly one cycle when digit_idx=N_DIGITS-1, prescaler=REFRESH_DIV-1 and the state is not OFF.
- Double buffer:
  - load copies value/dp_in into pending and sets pending_valid.
  - At the edge ending a frame_tick cycle, if pending_valid is set, pending is copied to active and pending_valid is cleared.
  - If load coincides with frame_tick, the new value/dp_in goes directly into active and pending_valid ends 0.
  - Repeated loads within one frame: the last one wins.
- Decode table (active-high segments):
  - 0:abcdef, 1:bc, 2:abdeg, 3:abcdg
  - 4:bcfg, 5:acdfg, 6:acdefg, 7:abc
  - 8:abcdefg, 9:abcdfg, A:abcefg, b:cdefg
  - C:adef, d:bcdeg, E:adefg, F:aefg
- Output polarity: invert seg/dp when SEG_ACTIVE_LOW=1; invert com when COM_ACTIVE_LOW=1.
- Leading-zero suppression:
  - With lz_en=1, digit k is blanked if active nibbles k..N_DIGITS-1 are all zero and k != 0.
  - A blanked digit keeps com inactive for its whole slot, and dp is suppressed too.
  - Digit 0 is never blanked.
- Latency: seg, dp and com are registered and reflect the state/digit of the previous cycle. The first SHOW output appears BLANK_CYCLES+1 cycles after entering GAP.
- Never more than one com is active at any time, including across enable and rst edges.

Decomposition:
- Package seg7_pkg:
  - The 16-entry hex-to-segment constant table.
  - Segment bit-index constants (SEG_A..SEG_G).
  - Scan state enum (OFF, GAP, SHOW).
- Sub-module seg7_hex_decode: combinational nibble to 7-bit active-high pattern. The top applies polarity.

Test Plan:
All scenarios use N_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2, both polarity parameters =1.
1. Reset: rst=1 for 3 cycles with enable=1 -> seg=7'h7F, dp=1, com=4'hF, frame_tick=0. The first frame after release shows "0000".
2. load value=16'h12AF, dp_in=4'b0100 -> from the next frame:
   - digit 0: com=4'hE, seg=7'h0E (F)
   - digit 1: com=4'hD, seg=7'h08 (A)
   - digit 2: com=4'hB, seg=7'h24 (2), dp=0
   - digit 3: com=4'h7, seg=7'h79 (1)
   - com=4'hF during every 2-cycle gap
3. lz_en=1:
   - value=16'h0050 -> slots 3 and 2 keep com=4'hF; digit 1 seg=7'h12 (5); digit 0 seg=7'h40 (0).
   - value=16'h0000 -> only digit 0 is lit.
4. Double buffer:
   - load mid-frame -> remaining digits of the current frame unchanged; the new value appears from the frame after frame_tick.
   - load in the frame_tick cycle -> applied to the very next frame.
   - two loads in one frame -> the second is displayed.
5. enable dropped during SHOW of digit 2 -> next cycle com=4'hF, seg=7'h7F. Re-enable -> digit 0 GAP restarts; frame_tick period stays 32 cycles.
6. rst pulsed mid-SHOW with pending_valid=1 -> outputs inactive next cycle; the pending value is discarded and "0000" is shown after release.
